// File: rtl/dac_update_ctrl_if.sv
// rtl/dac_update_ctrl_if.sv - voltage request handshake channel for dac_update_ctrl
interface dac_update_ctrl_if #(
  parameter int FLOAT_WIDTH = 64
);
  logic                   req_valid;
  logic                   req_ready;
  logic [FLOAT_WIDTH-1:0] req_voltage;

  modport master (output req_valid, output req_voltage, input  req_ready);
  modport slave  (input  req_valid, input  req_voltage, output req_ready);
endinterface

// File: rtl/dac_update_ctrl.sv
// rtl/dac_update_ctrl.sv - sequences voltage request -> conversion -> DAC load -> settle wait
// Optional input clamping to [CLAMP_LO, CLAMP_HI] under DAC_UPDATE_CTRL_CLAMP_EN.
module dac_update_ctrl #(
  parameter int                     FLOAT_WIDTH   = 64,
  parameter int                     INT_WIDTH     = 16,
  parameter int                     DAC_WIDTH     = 14,
  parameter int                     CONV_LAT      = 2,
  parameter int                     SETTLE_CYCLES = 125,
  parameter logic [FLOAT_WIDTH-1:0] CLAMP_HI      = 64'h000A_0000_0000_0000,
  parameter logic [FLOAT_WIDTH-1:0] CLAMP_LO      = 64'hFFF6_0000_0000_0001
) (
  input  logic                   clk,
  input  logic                   rst_n,
  dac_update_ctrl_if.slave       req,
  output logic [FLOAT_WIDTH-1:0] conv_voltage,
  input  logic [DAC_WIDTH-1:0]   conv_code,
  output logic [DAC_WIDTH-1:0]   dac_code,
  output logic                   dac_update,
  output logic                   settled,
  output logic                   busy,
  output logic                   clamp_hit
);

  if (CONV_LAT < 1 || CONV_LAT > 15 || SETTLE_CYCLES < 1 || SETTLE_CYCLES > 65535 ||
      INT_WIDTH >= FLOAT_WIDTH || $signed(CLAMP_LO) > $signed(CLAMP_HI)) begin : g_bad_param
    $error("dac_update_ctrl: illegal parameter set");
  end

  localparam logic [15:0] CONV_LOAD   = 16'(CONV_LAT - 1);
  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CONV, SETTLE} state_t;

  state_t                 state;
  logic [15:0]            cnt;
  logic [FLOAT_WIDTH-1:0] load_voltage;
  logic                   load_clamped;

`ifdef DAC_UPDATE_CTRL_CLAMP_EN
  always_comb begin
    load_voltage = req.req_voltage;
    load_clamped = 1'b0;
    if ($signed(req.req_voltage) > $signed(CLAMP_HI)) begin
      load_voltage = CLAMP_HI;
      load_clamped = 1'b1;
    end else if ($signed(req.req_voltage) < $signed(CLAMP_LO)) begin
      load_voltage = CLAMP_LO;
      load_clamped = 1'b1;
    end
  end
`else
  assign load_voltage = req.req_voltage;
  assign load_clamped = 1'b0;
`endif

  // Ready is decoded from the state register only, so no input reaches an output.
  assign req.req_ready = (state == IDLE);
  assign busy          = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      conv_voltage <= '0;
      dac_code     <= '0;
      dac_update   <= 1'b0;
      settled      <= 1'b0;
      clamp_hit    <= 1'b0;
    end else begin
      dac_update <= 1'b0;
      settled    <= 1'b0;
      clamp_hit  <= 1'b0;
      case (state)
        IDLE: begin
          if (req.req_valid) begin
            conv_voltage <= load_voltage;
            clamp_hit    <= load_clamped;
            cnt          <= CONV_LOAD;
            state        <= CONV;
          end
        end
        CONV: begin
          if (cnt == '0) begin
            dac_code   <= conv_code;
            dac_update <= 1'b1;
            cnt        <= SETTLE_LOAD;
            state      <= SETTLE;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            settled <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dac_update_ctrl.sv
// tb/tb_dac_update_ctrl.sv - testbench for dac_update_ctrl (table vectors, hand sequences, random vs. schedule model)
module tb_dac_update_ctrl;

  localparam int          CL       = 2;
  localparam int          SC       = 4;
  localparam logic [63:0] CLAMP_HI = 64'h000A_0000_0000_0000;
  localparam logic [63:0] CLAMP_LO = 64'hFFF6_0000_0000_0001;
  localparam logic [63:0] V1       = 64'h0001_0000_0000_0000;
  localparam logic [63:0] V2       = 64'h0002_8000_0000_0000;
  localparam logic [63:0] V20      = 64'h0014_0000_0000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dac_update_ctrl_if #(.FLOAT_WIDTH(64)) ifc0 ();
  dac_update_ctrl_if #(.FLOAT_WIDTH(64)) ifc1 ();

  logic [63:0] conv_voltage0, conv_voltage1;
  logic [13:0] conv_code0, conv_code1, dac_code0, dac_code1;
  logic        dac_update0, dac_update1, settled0, settled1;
  logic        busy0, busy1, clamp_hit0, clamp_hit1;

  dac_update_ctrl #(.CONV_LAT(CL), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .req(ifc0), .conv_voltage(conv_voltage0), .conv_code(conv_code0),
    .dac_code(dac_code0), .dac_update(dac_update0), .settled(settled0), .busy(busy0),
    .clamp_hit(clamp_hit0));

  dac_update_ctrl #(.CONV_LAT(1), .SETTLE_CYCLES(1)) dut_fast (
    .clk(clk), .rst_n(rst_n), .req(ifc1), .conv_voltage(conv_voltage1), .conv_code(conv_code1),
    .dac_code(dac_code1), .dac_update(dac_update1), .settled(settled1), .busy(busy1),
    .clamp_hit(clamp_hit1));

  int total = 0;
  int bad = 0;

  // Schedule model: each acceptance fixes the edges of its update, settle and next free slot.
  int          e = 0;
  int          m_free, m_k, m_upd, m_set;
  bit          m_hit;
  logic [63:0] m_conv;
  logic [13:0] m_dac;

  typedef struct {
    logic        v;
    logic [63:0] volt;
    logic [13:0] code;
    logic        rdy;
    logic        upd;
    logic        set;
    logic [13:0] dac;
    logic [63:0] conv;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got %h want %h", name, e, act, exp);
    end
  endtask

  function automatic logic [63:0] clampf(input logic [63:0] v, output bit hit);
    hit = 1'b0;
    clampf = v;
`ifdef DAC_UPDATE_CTRL_CLAMP_EN
    if ($signed(v) > $signed(CLAMP_HI)) begin
      clampf = CLAMP_HI;
      hit = 1'b1;
    end else if ($signed(v) < $signed(CLAMP_LO)) begin
      clampf = CLAMP_LO;
      hit = 1'b1;
    end
`endif
  endfunction

  task automatic model_reset();
    m_free = e;
    m_k    = -1;
    m_upd  = -1;
    m_set  = -1;
    m_hit  = 1'b0;
    m_conv = '0;
    m_dac  = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ifc0.req_valid = 1'b0;
    ifc1.req_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic step(input logic v, input logic [63:0] volt, input logic [13:0] code);
    bit h;
    logic [63:0] cv;
    ifc0.req_valid   = v;
    ifc0.req_voltage = volt;
    conv_code0       = code;
    @(posedge clk);
    if (v && e >= m_free) begin
      cv     = clampf(volt, h);
      m_conv = cv;
      m_hit  = h;
      m_k    = e;
      m_upd  = e + CL;
      m_set  = e + CL + SC;
      m_free = e + CL + SC + 1;
    end
    if (e == m_upd) m_dac = code;
    @(negedge clk);
    chk("req_ready",    64'(ifc0.req_ready), 64'(e + 1 >= m_free));
    chk("busy",         64'(busy0),          64'(e + 1 <  m_free));
    chk("dac_update",   64'(dac_update0),    64'(e == m_upd));
    chk("settled",      64'(settled0),       64'(e == m_set));
    chk("clamp_hit",    64'(clamp_hit0),     64'(e == m_k && m_hit));
    chk("dac_code",     64'(dac_code0),      64'(m_dac));
    chk("conv_voltage", conv_voltage0,       m_conv);
    e++;
  endtask

  function automatic logic [63:0] rand_volt();
    logic [63:0] pool[7];
    pool = '{V20, 64'hFFEC_0000_0000_0000, CLAMP_HI, CLAMP_HI + 64'd1, CLAMP_LO, CLAMP_LO - 64'd1, V1};
    if ($urandom_range(0, 2) == 0) return {$urandom, $urandom};
    return pool[$urandom_range(0, 6)];
  endfunction

  initial begin
    logic [63:0] exp_conv;
    bit          exp_hit;

    tbl[0] = '{1'b1, V1, 14'h000, 1'b0, 1'b0, 1'b0, 14'h000, V1};
    tbl[1] = '{1'b1, V2, 14'h111, 1'b0, 1'b0, 1'b0, 14'h000, V1};
    tbl[2] = '{1'b1, V2, 14'h123, 1'b0, 1'b1, 1'b0, 14'h123, V1};
    tbl[3] = '{1'b1, V2, 14'h3FF, 1'b0, 1'b0, 1'b0, 14'h123, V1};
    tbl[4] = '{1'b0, V2, 14'h2AA, 1'b0, 1'b0, 1'b0, 14'h123, V1};
    tbl[5] = '{1'b0, V2, 14'h155, 1'b0, 1'b0, 1'b0, 14'h123, V1};
    tbl[6] = '{1'b1, V2, 14'h055, 1'b1, 1'b0, 1'b1, 14'h123, V1};
    tbl[7] = '{1'b1, V2, 14'h0AA, 1'b0, 1'b0, 1'b0, 14'h123, V2};

    ifc0.req_valid = 1'b0; ifc0.req_voltage = '0; conv_code0 = '0;
    ifc1.req_valid = 1'b0; ifc1.req_voltage = '0; conv_code1 = 14'h2B7;
    do_reset();

    chk("rst_ready",    64'(ifc0.req_ready), 64'd1);
    chk("rst_dac_code", 64'(dac_code0),      64'd0);
    chk("rst_conv",     conv_voltage0,       64'd0);
    chk("rst_pulses",   64'({dac_update0, settled0, clamp_hit0, busy0}), 64'd0);

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].v, tbl[i].volt, tbl[i].code);
      chk("tbl_ready", 64'(ifc0.req_ready), 64'(tbl[i].rdy));
      chk("tbl_upd",   64'(dac_update0),    64'(tbl[i].upd));
      chk("tbl_set",   64'(settled0),       64'(tbl[i].set));
      chk("tbl_dac",   64'(dac_code0),      64'(tbl[i].dac));
      chk("tbl_conv",  conv_voltage0,       tbl[i].conv);
    end
    repeat (8) step(1'b0, V1, 14'h001);

    // +20 V request: clamped only when the clamp build option is on.
    step(1'b1, V20, 14'h010);
`ifdef DAC_UPDATE_CTRL_CLAMP_EN
    exp_conv = CLAMP_HI; exp_hit = 1'b1;
`else
    exp_conv = V20; exp_hit = 1'b0;
`endif
    chk("clamp_conv", conv_voltage0,   exp_conv);
    chk("clamp_hit",  64'(clamp_hit0), 64'(exp_hit));
    step(1'b0, V20, 14'h010);
    chk("clamp_hit_once", 64'(clamp_hit0), 64'd0);
    repeat (6) step(1'b0, V1, 14'h020);

    // Reset asserted two cycles into SETTLE.
    step(1'b1, V2, 14'h0F0);
    repeat (4) step(1'b0, V1, 14'h0F0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dac_code", 64'(dac_code0),      64'd0);
    chk("arst_conv",     conv_voltage0,       64'd0);
    chk("arst_ready",    64'(ifc0.req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (6) step(1'b0, V1, 14'h0F0);
    step(1'b1, V1, 14'h0C3);
    chk("post_rst_accept", 64'(ifc0.req_ready), 64'd0);
    repeat (6) step(1'b0, V1, 14'h0C3);

    // Continuous valid with changing voltage, then random traffic.
    for (int i = 0; i < 70; i++) step(1'b1, rand_volt(), 14'($urandom));
    for (int i = 0; i < 250; i++) step(1'($urandom_range(0, 3) != 0), rand_volt(), 14'($urandom));

    // Shortest configuration: update and settle in consecutive cycles, period 3.
    ifc1.req_voltage = V1;
    ifc1.req_valid   = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("fast_upd",   64'(dac_update1),    64'(i % 3 == 1));
      chk("fast_set",   64'(settled1),       64'(i % 3 == 2));
      chk("fast_ready", 64'(ifc1.req_ready), 64'(i % 3 == 2));
    end
    chk("fast_dac", 64'(dac_code1), 64'(14'h2B7));
    ifc1.req_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dac_update_ctrl.md
DAC_UPDATE_CTRL -- requirements
Module: dac_update_ctrl

Interface
REQ-001 Parameters: FLOAT_WIDTH, 64, signed fixed-point voltage word width; INT_WIDTH, 16, integer bits of the voltage word; DAC_WIDTH, 14, DAC code width.
REQ-002 Parameters: CONV_LAT, 2, conversion datapath latency in cycles (legal range 1..15); SETTLE_CYCLES, 125, DAC settle wait in cycles (legal range 1..65535).
REQ-003 Parameters: CLAMP_HI, 64'h000A_0000_0000_0000, +10 V; CLAMP_LO, 64'hFFF6_0000_0000_0001, -10 V + 1 LSB.
REQ-004 Ports: clk, input, 1, sole clock, rising edge.
REQ-005 Ports: rst_n, input, 1, asynchronous active-low reset.
REQ-006 Ports: req_valid, input, 1, voltage request valid.
REQ-007 Ports: req_ready, output, 1, controller can accept a request.
REQ-008 Ports: req_voltage, input, FLOAT_WIDTH, requested voltage, signed Q(INT_WIDTH).(FLOAT_WIDTH-INT_WIDTH).
REQ-009 Ports: conv_voltage, output, FLOAT_WIDTH, registered voltage driven to the conversion datapath.
REQ-010 Ports: conv_code, input, DAC_WIDTH, code returned by the conversion datapath.
REQ-011 Ports: dac_code, output, DAC_WIDTH, registered code driven to the DAC.
REQ-012 Ports: dac_update, output, 1, one-cycle pulse when dac_code changes.
REQ-013 Ports: settled, output, 1, one-cycle pulse when the settle wait completes.
REQ-014 Ports: busy, output, 1, high in CONV or SETTLE.
REQ-015 Ports: clamp_hit, output, 1, one-cycle pulse when an accepted request was clamped.

Function
REQ-016 FSM states: IDLE, CONV, SETTLE; req_ready = (state == IDLE); busy = !req_ready.
REQ-017 Handshake: a request is accepted at the rising edge where req_valid && req_ready; call that edge k.
REQ-018 At edge k: conv_voltage loads the (possibly clamped) req_voltage; state goes to CONV; the down-counter loads CONV_LAT-1.
REQ-019 In CONV: when the counter is 0, at edge k+CONV_LAT, dac_code loads conv_code, dac_update is high for the following cycle only, state goes to SETTLE, and the counter loads SETTLE_CYCLES-1.
REQ-020 In SETTLE: when the counter is 0, at edge k+CONV_LAT+SETTLE_CYCLES, state goes to IDLE and settled is high for the following cycle only.
REQ-021 The next acceptance is possible at edge k+CONV_LAT+SETTLE_CYCLES+1; the minimum request period is CONV_LAT+SETTLE_CYCLES+1 cycles.
REQ-022 req_valid and req_voltage are ignored outside IDLE; conv_voltage and dac_code hold between updates.
REQ-023 The counter is 16 bits and never wraps: it only loads or decrements toward 0.
REQ-024 No output is combinational from any input.

Reset
REQ-025 rst_n low asynchronously forces: state IDLE; counter 0; conv_voltage 0; dac_code 0; dac_update, settled, clamp_hit 0.
REQ-026 Reset asserted mid-CONV or mid-SETTLE aborts the update with no dac_update or settled pulse; req_ready is 1 from the first edge after rst_n rises.

Configuration
REQ-027 Macro DAC_UPDATE_CTRL_CLAMP_EN, when defined: signed req_voltage > CLAMP_HI is replaced by CLAMP_HI, and < CLAMP_LO by CLAMP_LO, before loading conv_voltage; clamp_hit pulses for the cycle after edge k when a replacement occurred.
REQ-028 Macro DAC_UPDATE_CTRL_CLAMP_EN, when undefined: req_voltage passes unchanged; clamp_hit is tied 0; no comparator logic is synthesized.

Verification
REQ-029 Reset, then request 64'h0001_0000_0000_0000 with CONV_LAT=2, SETTLE_CYCLES=4 -> dac_update in the cycle after edge k+2, settled in the cycle after edge k+6, req_ready high again at k+6.
REQ-030 req_valid held high continuously -> accepts exactly every 7 cycles; intervening req_voltage changes are ignored.
REQ-031 With CLAMP_EN defined, request 64'h0014_0000_0000_0000 (+20 V) -> conv_voltage = CLAMP_HI and clamp_hit pulses once; without CLAMP_EN -> passes unchanged and clamp_hit stays 0.
REQ-032 Assert rst_n low two cycles into SETTLE -> dac_code 0 immediately, no settled pulse, next request accepted normally.
REQ-033 Request with SETTLE_CYCLES=1, CONV_LAT=1 -> dac_update and settled in consecutive cycles; period 3 cycles.
